// File: rtl/hex_seg_mux.sv
// Two-digit time-multiplexed hex 7-segment driver with a shared segment bus and dead-time blanking.
// Optional: define HEX_SEG_MUX_BLANK_LEADING_ZERO_EN to blank the left digit when hex_val[7:4] is zero.
module hex_seg_mux #(
  parameter int unsigned CLK_FREQ       = 12_000_000,
  parameter int unsigned REFRESH_HZ     = 1_000,
  parameter int unsigned DEAD_CYCLES    = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hex_val,
  output logic       digit_sel,
  output logic [6:0] seg_pins
);

  localparam int unsigned    DIV      = CLK_FREQ / REFRESH_HZ;
  localparam int unsigned    CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [6:0]     SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = 7'h77;
      4'hB:    decode = 7'h7C;
      4'hC:    decode = 7'h39;
      4'hD:    decode = 7'h5E;
      4'hE:    decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             digit_sel_q, digit_sel_d;
  logic [6:0]       seg_q, seg_d;
  logic             wrap;
  logic             dead_next;
  logic [3:0]       nibble;
  logic [6:0]       pattern;

  always_comb begin
    wrap        = (cnt_q == CNT_MAX);
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    digit_sel_d = digit_sel_q ^ wrap;
  end

  // With no dead time the comparison would be constant, so it is not built at all.
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign dead_next = 1'b0;
  end else begin : g_dead
    assign dead_next = (cnt_d < CNT_W'(DEAD_CYCLES));
  end

  // NOTE: every signal gets a value before any conditional update so no latch is inferred.
  always_comb begin
    nibble  = digit_sel_d ? hex_val[3:0] : hex_val[7:4];
    pattern = decode(nibble);
`ifdef HEX_SEG_MUX_BLANK_LEADING_ZERO_EN
    if (!digit_sel_d && (hex_val[7:4] == 4'h0)) pattern = 7'h00;
`endif
    if (dead_next) seg_d = SEG_DARK;
    else           seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
  end

  // NOTE: non-blocking assignments so all flops sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      digit_sel_q <= 1'b0;
      seg_q       <= SEG_DARK;
    end else begin
      cnt_q       <= cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign seg_pins  = seg_q;

endmodule

// File: tb/tb_hex_seg_mux.sv
// Self-checking bench for hex_seg_mux: three instances (dead time 1/3/0, both polarities) at DIV=10.
// Expected values come from hand-computed vectors and the decode table; k counts edges since reset release.
module tb_hex_seg_mux;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] hex_val;
  logic       sel_a, sel_b, sel_c;
  logic [6:0] seg_a, seg_b, seg_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  hex_seg_mux #(.CLK_FREQ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(1), .SEG_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .hex_val(hex_val), .digit_sel(sel_a), .seg_pins(seg_a));
  hex_seg_mux #(.CLK_FREQ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(3), .SEG_ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .hex_val(hex_val), .digit_sel(sel_b), .seg_pins(seg_b));
  hex_seg_mux #(.CLK_FREQ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .hex_val(hex_val), .digit_sel(sel_c), .seg_pins(seg_c));

  typedef struct {
    logic [7:0] val;
    logic [6:0] left_n;
    logic [6:0] right_n;
  } vec_t;

  vec_t vecs[10];

  logic [6:0] dec_tbl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d hex=%h got=%h want=%h", name, cyc, hex_val, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int k, input logic [7:0] v, input int dead,
                                          input bit active_low);
    logic [6:0] pat;
    logic       sel;
    sel = ((k / DIV) % 2) == 1;
    if (k == 0 || (k % DIV) < dead) begin
      pat = 7'h00;
    end else begin
      pat = sel ? dec_tbl[v[3:0]] : dec_tbl[v[7:4]];
`ifdef HEX_SEG_MUX_BLANK_LEADING_ZERO_EN
      if (!sel && v[7:4] == 4'h0) pat = 7'h00;
`endif
    end
    return active_low ? ~pat : pat;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all();
    logic [6:0] es;
    es = {6'b0, ((cyc / DIV) % 2) == 1};
    check("sel_a", {6'b0, sel_a}, es);
    check("sel_c", {6'b0, sel_c}, es);
    check("seg_a", seg_a, exp_seg(cyc, hex_val, 1, 1'b1));
    check("seg_b", seg_b, exp_seg(cyc, hex_val, 3, 1'b0));
    check("seg_c", seg_c, exp_seg(cyc, hex_val, 0, 1'b1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"},   {6'b0, sel_a}, 7'h00);
    check({tag, "_seg_a"}, seg_a, 7'h7F);
    check({tag, "_seg_b"}, seg_b, 7'h00);
    check({tag, "_seg_c"}, seg_c, 7'h7F);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog k=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h3A, 7'h30, 7'h08};
`ifdef HEX_SEG_MUX_BLANK_LEADING_ZERO_EN
    vecs[1] = '{8'h05, 7'h7F, 7'h12};
    vecs[9] = '{8'h00, 7'h7F, 7'h40};
`else
    vecs[1] = '{8'h05, 7'h40, 7'h12};
    vecs[9] = '{8'h00, 7'h40, 7'h40};
`endif
    vecs[2] = '{8'h15, 7'h79, 7'h12};
    vecs[3] = '{8'hF0, 7'h0E, 7'h40};
    vecs[4] = '{8'h8B, 7'h00, 7'h03};
    vecs[5] = '{8'hC9, 7'h46, 7'h10};
    vecs[6] = '{8'hD6, 7'h21, 7'h02};
    vecs[7] = '{8'hE4, 7'h06, 7'h19};
    vecs[8] = '{8'h27, 7'h24, 7'h78};

    rst_n   = 1'b0;
    hex_val = 8'h3A;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");

    rst_n = 1'b1;
    cyc   = 0;
    check_all();
    repeat (40) begin
      tick();
      check_all();
    end

    foreach (vecs[i]) begin
      hex_val = vecs[i].val;
      repeat (2 * DIV) begin
        tick();
        if ((cyc % DIV) < 1)
          check("vec_dark", seg_a, 7'h7F);
        else if (((cyc / DIV) % 2) == 1)
          check("vec_right", seg_a, vecs[i].right_n);
        else
          check("vec_left", seg_a, vecs[i].left_n);
        check_all();
      end
    end

    for (int v = 0; v < 256; v++) begin
      hex_val = 8'(v);
      repeat (2 * DIV) begin
        tick();
        check_all();
      end
    end

    // Mid-slot value change shows on the very next cycle.
    hex_val = 8'h12;
    while ((cyc % DIV) != 5) tick();
    hex_val = 8'h34;
    tick();
    check_all();
    tick();
    check_all();

    // Asynchronous reset between edges, mid-slot.
    while ((cyc % DIV) != 4 || ((cyc / DIV) % 2) != 1) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    cyc   = 0;
    check_all();
    repeat (25) begin
      tick();
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_seg_mux.md
Name: hex_seg_mux

Overview:
Two-digit, time-multiplexed 7-segment driver that shows an 8-bit value as two hex digits on a dual-digit PMOD display. There is one shared segment bus and one digit-select line. It sits at the top level, beside the control unit and loader. Its input shows the loader's last byte while loading, and the CU exit code once loading is done.

Parameters:
CLK_FREQ, 12_000_000, input clock frequency in Hz.
REFRESH_HZ, 1_000, digit toggle rate. DIV = CLK_FREQ/REFRESH_HZ clock cycles per digit slot; DIV must be ≥ 2.
DEAD_CYCLES, 1, number of cycles at the start of each slot with all segments dark (anti-ghosting). Must be < DIV.
SEG_ACTIVE_LOW, 1, 1 = a lit segment drives 0; 0 = a lit segment drives 1.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
hex_val  in  8  value to display; [7:4] is the left digit, [3:0] is the right digit.
digit_sel  out  1  0 = left (high-nibble) digit active; 1 = right (low-nibble) digit active.
seg_pins  out  7  segment bus in order {g,f,e,d,c,b,a}; seg_pins[0] = a.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: slot counter = 0, digit_sel = 0, seg_pins = all dark (7'h7F when SEG_ACTIVE_LOW=1, 7'h00 otherwise).
- Slot counter:
  - Counts 0..DIV-1 and wraps to 0.
  - On the cycle it wraps, digit_sel toggles.
  - First toggle occurs DIV cycles after reset release.
- Segment register, updated every cycle:
  - Dark if the next counter value is < DEAD_CYCLES.
  - Otherwise, the decoded nibble selected by the next digit_sel value (high nibble when 0, low nibble when 1).
- Effect: each slot starts with exactly DEAD_CYCLES dark cycles, aligned with the digit_sel edge, then the digit pattern for the rest of the slot.
- hex_val is not latched. A change appears on seg_pins one cycle later, unless that cycle is a dead cycle. Changes mid-slot are displayed immediately, with no tearing protection.
- Decode table, active-high {g..a}:
  0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  With SEG_ACTIVE_LOW=1 the output is the bitwise inverse.
- DEAD_CYCLES=0: no dark period; patterns switch on the same edge as digit_sel.
- Reset asserted mid-slot: outputs immediately return to reset values, asynchronously, regardless of clock. The counter restarts from 0 after release.
- No X propagation: every hex_val value maps to a defined pattern.

Optional Feature:
Macro HEX_SEG_MUX_BLANK_LEADING_ZERO_EN.
- Defined: when hex_val[7:4]==0, the left-digit slot is driven dark for the whole slot. digit_sel still toggles normally. The right digit is always shown.
- Undefined: the left digit always shows its nibble, including '0'.

Test Plan:
- Reset: hold rst_n=0 → digit_sel=0, seg_pins=7'h7F. Release → seg_pins stays 7'h7F during the first DEAD_CYCLES cycles.
- Basic decode: CLK_FREQ=1000, REFRESH_HZ=100 (DIV=10), DEAD_CYCLES=1, hex_val=8'h3A.
  - Left slot: seg_pins=7'h30.
  - After 10 cycles: digit_sel=1, one dark cycle, then seg_pins=7'h08.
  - digit_sel keeps toggling every 10 cycles.
- Full table sweep: step hex_val through 8'h00..8'hFF.
  - seg_pins matches the inverted decode table in both slots.
  - With SEG_ACTIVE_LOW=0, seg_pins matches the non-inverted table.
- Dead time: DEAD_CYCLES=3, DIV=10 → exactly 3 dark cycles, then 7 pattern cycles, in each slot.
- Async reset mid-slot: assert rst_n low between clock edges → outputs reach reset values without a clock edge. Counter restarts from 0 after release.
- Leading zero, macro defined: hex_val=8'h05 → left slot dark (7'h7F), right slot 7'h12. hex_val=8'h15 → left slot 7'h79.
